// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Summary  : Shared types for the pipeline hazard/forwarding controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEM   = 2'd1,
    FWD_WB    = 2'd2,
    FWD_STALL = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDWAIT = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FLUSH  = 2'd3
  } hz_state_e;

  localparam int unsigned CNT_W = 3;

  // Mem is the younger producer, so it wins over wb.
  function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module   : fwd_match
// Summary  : Compares one execute source register against mem/wb dest tags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_match #(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] mem_regd,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] wb_regd,
  input  logic          wb_regwrite,
  output logic          mem_hit,
  output logic          wb_hit
);

  logic src_nz;

  // x0 is hardwired to zero, so it never forwards or stalls.
  assign src_nz  = (src != '0);
  assign mem_hit = mem_regwrite && (mem_regd == src) && src_nz;
  assign wb_hit  = wb_regwrite  && (wb_regd  == src) && src_nz;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Summary  : Forwarding selects, load-use stalls and branch/jal flush sequencing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RW           = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [RW-1:0]   ex_reg1,
  input  logic [RW-1:0]   ex_reg2,
  input  logic [RW-1:0]   mem_regD,
  input  logic            mem_regwrite,
  input  logic            mem_load,
  input  logic [RW-1:0]   wb_regD,
  input  logic            wb_regwrite,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  input  logic            branch_taken,
  input  logic            jal_taken,
  output logic            stall,
  output logic            flush,
  output logic [1:0]      fwd1_sel,
  output logic [1:0]      fwd2_sel,
  output logic [XLEN-1:0] stall_val
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  stall_val_q, stall_val_d;
  logic             hit1_q, hit1_d;
  logic             hit2_q, hit2_d;

  logic     mem_hit1, wb_hit1, mem_hit2, wb_hit2;
  logic     redirect, load_use;
  fwd_sel_e norm1, norm2, sel1, sel2;

  fwd_match #(.RW(RW)) u_match1 (
    .src          (ex_reg1),
    .mem_regd     (mem_regD),
    .mem_regwrite (mem_regwrite),
    .wb_regd      (wb_regD),
    .wb_regwrite  (wb_regwrite),
    .mem_hit      (mem_hit1),
    .wb_hit       (wb_hit1)
  );

  fwd_match #(.RW(RW)) u_match2 (
    .src          (ex_reg2),
    .mem_regd     (mem_regD),
    .mem_regwrite (mem_regwrite),
    .wb_regd      (wb_regD),
    .wb_regwrite  (wb_regwrite),
    .mem_hit      (mem_hit2),
    .wb_hit       (wb_hit2)
  );

  assign redirect = branch_taken | jal_taken;
  assign load_use = ex_valid && mem_load && (mem_hit1 || mem_hit2);
  assign norm1    = fwd_pick(mem_hit1, wb_hit1);
  assign norm2    = fwd_pick(mem_hit2, wb_hit2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_val_q <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_val_q <= stall_val_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_val_d = stall_val_q;
    hit1_d      = hit1_q;
    hit2_d      = hit2_q;
    stall       = 1'b0;
    flush       = 1'b0;
    sel1        = FWD_RF;
    sel2        = FWD_RF;

    if (redirect) begin
      // A redirect aborts any pending load replay and restarts the flush window.
      flush   = 1'b1;
      cnt_d   = FLUSH_LOAD;
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            stall  = 1'b1;
            hit1_d = mem_hit1;
            hit2_d = mem_hit2;
            if (ld_valid) begin
              stall_val_d = ld_data;
              state_d     = ST_REPLAY;
            end else begin
              state_d     = ST_LDWAIT;
            end
          end else begin
            sel1 = norm1;
            sel2 = norm2;
          end
        end
        ST_LDWAIT: begin
          stall = 1'b1;
          if (ld_valid) begin
            stall_val_d = ld_data;
            state_d     = ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          sel1    = hit1_q ? FWD_STALL : norm1;
          sel2    = hit2_q ? FWD_STALL : norm2;
          state_d = ST_RUN;
        end
        ST_FLUSH: begin
          if (cnt_q != '0) begin
            flush = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Keep control outputs quiet while reset is asserted, whatever the inputs show.
    if (!rst) begin
      stall = 1'b0;
      flush = 1'b0;
      sel1  = FWD_RF;
      sel2  = FWD_RF;
    end
  end

  assign fwd1_sel  = sel1;
  assign fwd2_sel  = sel2;
  assign stall_val = stall_val_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Summary  : Directed scoreboard bench for hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic [RW-1:0]   ex_reg1, ex_reg2;
  logic [RW-1:0]   mem_regD;
  logic            mem_regwrite, mem_load;
  logic [RW-1:0]   wb_regD;
  logic            wb_regwrite;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            branch_taken, jal_taken;
  logic            stall, flush;
  logic [1:0]      fwd1_sel, fwd2_sel;
  logic [XLEN-1:0] stall_val;

  hazard_ctrl #(.XLEN(XLEN), .RW(RW), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .ex_valid     (ex_valid),
    .ex_reg1      (ex_reg1),
    .ex_reg2      (ex_reg2),
    .mem_regD     (mem_regD),
    .mem_regwrite (mem_regwrite),
    .mem_load     (mem_load),
    .wb_regD      (wb_regD),
    .wb_regwrite  (wb_regwrite),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .branch_taken (branch_taken),
    .jal_taken    (jal_taken),
    .stall        (stall),
    .flush        (flush),
    .fwd1_sel     (fwd1_sel),
    .fwd2_sel     (fwd2_sel),
    .stall_val    (stall_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           nm;
    logic            st;
    logic            fl;
    logic            chk_sel;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic            chk_sv;
    logic [XLEN-1:0] sv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input string fld,
                       input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.nm, "stall", XLEN'(stall), XLEN'(mon_e.st));
      check(mon_e.nm, "flush", XLEN'(flush), XLEN'(mon_e.fl));
      if (mon_e.chk_sel) begin
        check(mon_e.nm, "fwd1_sel", XLEN'(fwd1_sel), XLEN'(mon_e.s1));
        check(mon_e.nm, "fwd2_sel", XLEN'(fwd2_sel), XLEN'(mon_e.s2));
      end
      if (mon_e.chk_sv) check(mon_e.nm, "stall_val", stall_val, mon_e.sv);
    end
  end

  task automatic expect_out(input string nm, input logic st, input logic fl,
                            input logic cs, input logic [1:0] s1, input logic [1:0] s2,
                            input logic cv, input logic [XLEN-1:0] sv);
    exp_t e;
    e.nm = nm; e.st = st; e.fl = fl; e.chk_sel = cs;
    e.s1 = s1; e.s2 = s2; e.chk_sv = cv; e.sv = sv;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_valid = 1'b0; ex_reg1 = '0; ex_reg2 = '0;
    mem_regD = '0; mem_regwrite = 1'b0; mem_load = 1'b0;
    wb_regD = '0; wb_regwrite = 1'b0;
    ld_valid = 1'b0; ld_data = '0;
    branch_taken = 1'b0; jal_taken = 1'b0;
  endtask

  task automatic set_ex(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    ex_valid = v; ex_reg1 = r1; ex_reg2 = r2;
  endtask

  task automatic set_mem(input logic [RW-1:0] rd, input logic we, input logic ld);
    mem_regD = rd; mem_regwrite = we; mem_load = ld;
  endtask

  task automatic set_wb(input logic [RW-1:0] rd, input logic we);
    wb_regD = rd; wb_regwrite = we;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick(); tick();
    expect_out("reset_hold", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);
    tick(); rst_n = 1'b1;
    expect_out("idle", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);

    // Forwarding patterns
    tick(); clear_in(); set_mem(5'd5, 1, 0); set_ex(1, 5'd5, 5'd5);
    expect_out("fwd_mem_both", 0, 0, 1, 2'd1, 2'd1, 0, 32'h0);
    tick(); clear_in(); set_wb(5'd5, 1); set_ex(1, 5'd5, 5'd5);
    expect_out("fwd_wb_both", 0, 0, 1, 2'd2, 2'd2, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd5, 1, 0); set_wb(5'd6, 1); set_ex(1, 5'd6, 5'd5);
    expect_out("fwd_mixed", 0, 0, 1, 2'd2, 2'd1, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd7, 1, 0); set_wb(5'd7, 1); set_ex(1, 5'd7, 5'd0);
    expect_out("mem_beats_wb", 0, 0, 1, 2'd1, 2'd0, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd0, 1, 0); set_wb(5'd0, 1); set_ex(1, 5'd0, 5'd0);
    expect_out("x0_never", 0, 0, 1, 2'd0, 2'd0, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd7, 0, 0); set_wb(5'd7, 1); set_ex(1, 5'd7, 5'd7);
    expect_out("mem_nowrite", 0, 0, 1, 2'd2, 2'd2, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd7, 1, 1); set_ex(0, 5'd7, 5'd7);
    expect_out("load_no_exvalid", 0, 0, 1, 2'd1, 2'd1, 0, 32'h0);

    // Load-use on src2 with three wait cycles
    tick(); clear_in(); set_mem(5'd3, 1, 1); set_ex(1, 5'd4, 5'd3);
    expect_out("lu_detect", 1, 0, 0, 2'd0, 2'd0, 1, 32'h0);
    tick(); set_mem(5'd0, 0, 0);
    expect_out("lu_wait1", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick();
    expect_out("lu_wait2", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
    expect_out("lu_wait3", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); ld_valid = 1'b0; ld_data = '0; set_wb(5'd4, 1);
    expect_out("lu_replay", 0, 0, 1, 2'd2, 2'd3, 1, 32'hDEADBEEF);
    tick();
    expect_out("lu_after", 0, 0, 1, 2'd2, 2'd0, 1, 32'hDEADBEEF);
    tick(); clear_in(); ld_valid = 1'b1; ld_data = 32'h12345678;
    expect_out("ld_ignored_a", 0, 0, 1, 2'd0, 2'd0, 1, 32'hDEADBEEF);
    tick(); clear_in();
    expect_out("ld_ignored_b", 0, 0, 1, 2'd0, 2'd0, 1, 32'hDEADBEEF);

    // Load data arrives in the detecting cycle: straight to replay
    tick(); set_mem(5'd9, 1, 1); set_ex(1, 5'd9, 5'd9); ld_valid = 1'b1; ld_data = 32'hA5;
    expect_out("lu_fast_detect", 1, 0, 0, 2'd0, 2'd0, 1, 32'hDEADBEEF);
    tick(); clear_in(); set_ex(1, 5'd9, 5'd9);
    expect_out("lu_fast_replay", 0, 0, 1, 2'd3, 2'd3, 1, 32'hA5);
    tick();
    expect_out("lu_fast_run", 0, 0, 1, 2'd0, 2'd0, 1, 32'hA5);

    // Asynchronous reset in the middle of LDWAIT
    tick(); clear_in(); set_mem(5'd3, 1, 1); set_ex(1, 5'd0, 5'd3);
    expect_out("rst_detect", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); set_mem(5'd0, 0, 0);
    expect_out("rst_wait", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); #2; rst_n = 1'b0; set_mem(5'd3, 1, 1);
    expect_out("rst_async", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);
    tick(); clear_in();
    expect_out("rst_held", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);
    tick(); rst_n = 1'b1; set_mem(5'd5, 1, 0); set_ex(1, 5'd5, 5'd0);
    expect_out("rst_run", 0, 0, 1, 2'd1, 2'd0, 1, 32'h0);
    tick(); clear_in(); ld_valid = 1'b1; ld_data = 32'h1111;
    expect_out("rst_ld_ign_a", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);
    tick(); clear_in();
    expect_out("rst_ld_ign_b", 0, 0, 1, 2'd0, 2'd0, 1, 32'h0);

    // Branch during LDWAIT
    tick(); set_mem(5'd3, 1, 1); set_ex(1, 5'd4, 5'd3);
    expect_out("br_detect", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); set_mem(5'd0, 0, 0);
    expect_out("br_wait", 1, 0, 0, 2'd0, 2'd0, 0, 32'h0);
    tick(); branch_taken = 1'b1;
    expect_out("br_flush1", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick(); clear_in(); set_mem(5'd5, 1, 0); set_ex(1, 5'd5, 5'd5);
    expect_out("br_flush2", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick();
    expect_out("br_run", 0, 0, 1, 2'd1, 2'd1, 0, 32'h0);

    // Redirect beats a simultaneous load-use
    tick(); clear_in(); set_mem(5'd3, 1, 1); set_ex(1, 5'd3, 5'd3); jal_taken = 1'b1;
    expect_out("prio_flush1", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick(); clear_in();
    expect_out("prio_flush2", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick();
    expect_out("prio_run", 0, 0, 1, 2'd0, 2'd0, 0, 32'h0);

    // jal then branch one cycle later extends the flush window
    tick(); jal_taken = 1'b1;
    expect_out("ext_flush1", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick(); jal_taken = 1'b0; branch_taken = 1'b1;
    expect_out("ext_flush2", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick(); branch_taken = 1'b0; set_mem(5'd7, 1, 0); set_wb(5'd7, 1); set_ex(1, 5'd7, 5'd0);
    expect_out("ext_flush3", 0, 1, 1, 2'd0, 2'd0, 0, 32'h0);
    tick();
    expect_out("ext_run", 0, 0, 1, 2'd1, 2'd0, 0, 32'h0);

    tick(); clear_in();
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
